// File: rtl/traffic_light_fsm.sv
// Two-road traffic-light controller with per-phase interval countdown,
// all-red clearance, pedestrian green shortening and night flashing-yellow.
// Road 1 is EW (LR1/LY1/LG1), road 2 is NS (LR2/LY2/LG2).
module traffic_light_fsm #(
  parameter int GREEN_NS = 25,
  parameter int GREEN_EW = 25,
  parameter int YELLOW   = 3,
  parameter int ALLRED   = 1,
  parameter int PED_MIN  = 5,
  parameter int CNT_W    = 6
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ped_req,
  input  logic             night,
  output logic             LR1,
  output logic             LY1,
  output logic             LG1,
  output logic             LR2,
  output logic             LY2,
  output logic             LG2,
  output logic [CNT_W-1:0] remain,
  output logic             ped_pending,
  output logic             eLED01,
  output logic             eLED23
);

  typedef enum logic [2:0] {
    NS_GO  = 3'd0,
    NS_YEL = 3'd1,
    CLR_A  = 3'd2,
    EW_GO  = 3'd3,
    EW_YEL = 3'd4,
    CLR_B  = 3'd5,
    FLASH  = 3'd6
  } state_t;

  // Count reload values: a phase of D ticks counts D-1 down to 0.
  localparam logic [CNT_W-1:0] LD_GNS = CNT_W'(GREEN_NS - 1);
  localparam logic [CNT_W-1:0] LD_GEW = CNT_W'(GREEN_EW - 1);
  localparam logic [CNT_W-1:0] LD_Y   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_PED = CNT_W'(PED_MIN - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             phase, phase_n;
  logic             ped_n;
  logic             eled, eled_n;
  logic             is_green;

  // State, countdown, flash phase, pedestrian latch and display enable.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NS_GO;
      count       <= LD_GNS;
      phase       <= 1'b0;
      ped_pending <= 1'b0;
      eled        <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      phase       <= phase_n;
      ped_pending <= ped_n;
      eled        <= eled_n;
    end
  end

  assign is_green = (state == NS_GO) || (state == EW_GO);

  // Next-state / countdown. A pending pedestrian shortening load takes
  // priority over a coincident tick; it can never collide with a phase end
  // because it only fires while count > PED_MIN-1 >= 0.
  always_comb begin
    state_n = state;
    count_n = count;
    phase_n = phase;
    ped_n   = ped_pending | ped_req;
    if (state == FLASH) begin
      ped_n   = 1'b0;
      count_n = '0;
      if (tick) begin
        phase_n = ~phase;
        if (!night) begin
          state_n = CLR_B;
          count_n = LD_AR;
        end
      end
    end else if (is_green && ped_pending && (count > LD_PED)) begin
      count_n = LD_PED;
    end else if (tick) begin
      if (count != '0) begin
        count_n = count - ONE;
      end else begin
        unique case (state)
          NS_GO: begin
            state_n = NS_YEL;
            count_n = LD_Y;
          end
          NS_YEL: begin
            state_n = CLR_A;
            count_n = LD_AR;
            ped_n   = 1'b0;
          end
          CLR_A: begin
            if (night) begin
              state_n = FLASH;
              count_n = '0;
              phase_n = 1'b1;
              ped_n   = 1'b0;
            end else begin
              state_n = EW_GO;
              count_n = LD_GEW;
            end
          end
          EW_GO: begin
            state_n = EW_YEL;
            count_n = LD_Y;
          end
          EW_YEL: begin
            state_n = CLR_B;
            count_n = LD_AR;
            ped_n   = 1'b0;
          end
          CLR_B: begin
            if (night) begin
              state_n = FLASH;
              count_n = '0;
              phase_n = 1'b1;
              ped_n   = 1'b0;
            end else begin
              state_n = NS_GO;
              count_n = LD_GNS;
            end
          end
          default: begin
            // Unused encoding: recover to the reset phase.
            state_n = NS_GO;
            count_n = LD_GNS;
            ped_n   = 1'b0;
          end
        endcase
      end
    end
    eled_n = (state_n != FLASH);
  end

  // Lamp decode purely from registered state and flash phase.
  always_comb begin
    LR1 = 1'b0;
    LY1 = 1'b0;
    LG1 = 1'b0;
    LR2 = 1'b0;
    LY2 = 1'b0;
    LG2 = 1'b0;
    unique case (state)
      NS_GO:  begin LG2 = 1'b1; LR1 = 1'b1; end
      NS_YEL: begin LY2 = 1'b1; LR1 = 1'b1; end
      CLR_A:  begin LR1 = 1'b1; LR2 = 1'b1; end
      EW_GO:  begin LG1 = 1'b1; LR2 = 1'b1; end
      EW_YEL: begin LY1 = 1'b1; LR2 = 1'b1; end
      CLR_B:  begin LR1 = 1'b1; LR2 = 1'b1; end
      FLASH:  begin LY1 = phase; LY2 = phase; end
      default: begin LR1 = 1'b1; LR2 = 1'b1; end
    endcase
  end

  assign remain = count;
  assign eLED01 = eled;
  assign eLED23 = eled;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: phase-position / ticks-left model, checked
// every cycle, plus directed literal checks for the listed scenarios.
module tb_traffic_light_fsm;
  localparam int GNS = 5, GEW = 5, YEL = 2, AR = 1, PMIN = 2, CW = 4;

  logic clk1 = 1'b0, rst_n = 1'b0, tick = 1'b0, ped_req = 1'b0, night = 1'b0;
  logic LR1, LY1, LG1, LR2, LY2, LG2;
  logic [CW-1:0] remain;
  logic ped_pending, eLED01, eLED23;

  int n_tests = 0, n_fail = 0;
  bit done = 1'b0;
  int tcnt = 0;

  // Model: mp = position in the 6-phase cycle (6 = flashing), left = ticks
  // still to come in the phase including the one that ends it.
  int mp, left;
  bit m_ped, m_ph, m_eled;

  traffic_light_fsm #(.GREEN_NS(GNS), .GREEN_EW(GEW), .YELLOW(YEL), .ALLRED(AR),
                      .PED_MIN(PMIN), .CNT_W(CW)) dut (
    .clk1(clk1), .rst_n(rst_n), .tick(tick), .ped_req(ped_req), .night(night),
    .LR1(LR1), .LY1(LY1), .LG1(LG1), .LR2(LR2), .LY2(LY2), .LG2(LG2),
    .remain(remain), .ped_pending(ped_pending), .eLED01(eLED01), .eLED23(eLED23));

  always #5 clk1 = ~clk1;

  function automatic int dur(int p);
    case (p)
      0: return GNS;
      1, 4: return YEL;
      3: return GEW;
      default: return AR;
    endcase
  endfunction

  // {LR1,LY1,LG1,LR2,LY2,LG2}
  function automatic logic [5:0] lamps_of(int p, bit ph);
    case (p)
      0: return 6'b100_001;
      1: return 6'b100_010;
      3: return 6'b001_100;
      4: return 6'b010_100;
      6: return {1'b0, ph, 1'b0, 1'b0, ph, 1'b0};
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic model_reset();
    mp = 0; left = GNS; m_ped = 1'b0; m_ph = 1'b0; m_eled = 1'b0;
  endtask

  task automatic model_step(bit t, bit p, bit n);
    bit np;
    if (!rst_n) begin model_reset(); return; end
    np = m_ped | p;
    if (mp == 6) begin
      np = 1'b0;
      if (t) begin
        m_ph = !m_ph;
        if (!n) begin mp = 5; left = AR; end
      end
    end else if ((mp == 0 || mp == 3) && m_ped && left > PMIN) begin
      left = PMIN;
    end else if (t) begin
      left--;
      if (left == 0) begin
        if ((mp == 2 || mp == 5) && n) begin
          mp = 6; left = 1; m_ph = 1'b1; np = 1'b0;
        end else begin
          mp = (mp + 1) % 6;
          left = dur(mp);
          if (mp == 2 || mp == 5) np = 1'b0;
        end
      end
    end
    m_ped = np;
    m_eled = (mp != 6);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic cyc_t(bit t, bit p, bit n);
    tick = t; ped_req = p; night = n;
    @(posedge clk1);
    model_step(t, p, n);
    #1;
  endtask

  // Tick every 4th clock.
  task automatic cyc(bit p, bit n);
    bit t;
    t = (tcnt % 4 == 3);
    tcnt++;
    cyc_t(t, p, n);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk1) begin
    if (!done) begin
      check("lamps", {LR1, LY1, LG1, LR2, LY2, LG2}, lamps_of(mp, m_ph));
      check("remain", remain, left - 1);
      check("ped_pending", ped_pending, m_ped);
      check("eLED01", eLED01, m_eled);
      check("eLED23", eLED23, m_eled);
    end
  end

  initial begin
    int k;
    bit nl;
    model_reset();
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    check("rst_lamps", {LR1, LY1, LG1, LR2, LY2, LG2}, 6'b100_001);
    check("rst_remain", remain, 4);
    check("rst_eled", eLED01, 0);

    // Release and free run of one full 16-tick cycle.
    rst_n = 1'b1;
    tcnt = 0;
    cyc(1'b0, 1'b0);
    check("rel_remain", remain, 4);
    check("rel_eled", eLED01, 1);
    check("rel_lamps", {LR1, LY1, LG1, LR2, LY2, LG2}, 6'b100_001);
    while (tcnt < 64) cyc(1'b0, 1'b0);
    check("cycle16_remain", remain, 4);
    check("cycle16_lamps", {LR1, LY1, LG1, LR2, LY2, LG2}, 6'b100_001);

    // Pedestrian request at remain=4 shortens to remain=1.
    cyc(1'b1, 1'b0);
    check("ped_latch", ped_pending, 1);
    check("ped_latch_remain", remain, 4);
    cyc(1'b0, 1'b0);
    check("ped_short", remain, 1);
    k = 0;
    while (mp != 1 && k < 100) begin cyc(1'b0, 1'b0); k++; end
    if (k >= 100) timeout("wait_ns_yel");
    check("ped_yel_lamps", {LR1, LY1, LG1, LR2, LY2, LG2}, 6'b100_010);
    k = 0;
    while (mp != 2 && k < 100) begin cyc(1'b0, 1'b0); k++; end
    if (k >= 100) timeout("wait_clr_a");
    check("ped_clr", ped_pending, 0);

    // Request at remain=1: no reload.
    k = 0;
    while (!(mp == 0 && left == 2 && tcnt % 4 == 0) && k < 300) begin cyc(1'b0, 1'b0); k++; end
    if (k >= 300) timeout("wait_rem1");
    cyc(1'b1, 1'b0);
    check("ped_rem1_latch", ped_pending, 1);
    cyc(1'b0, 1'b0);
    check("ped_rem1_noload", remain, 1);

    // Request one cycle before a tick at remain=3: load wins over decrement.
    k = 0;
    while (!(mp == 0 && left == 4 && tcnt % 4 == 2) && k < 300) begin cyc(1'b0, 1'b0); k++; end
    if (k >= 300) timeout("wait_rem3");
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("coincident_remain", remain, 1);

    // Night entry from EW_GO, flash, then exit.
    k = 0;
    while (mp != 3 && k < 300) begin cyc(1'b0, 1'b0); k++; end
    if (k >= 300) timeout("wait_ew_go");
    k = 0;
    while (mp != 6 && k < 200) begin cyc(1'b0, 1'b1); k++; end
    if (k >= 200) timeout("wait_flash");
    check("flash_ly1", LY1, 1);
    check("flash_ly2", LY2, 1);
    check("flash_eled", eLED01, 0);
    repeat (4) cyc(1'b0, 1'b1);
    check("flash_toggle", LY1, 0);
    repeat (4) cyc(1'b1, 1'b1);
    check("flash_ped_held", ped_pending, 0);
    k = 0;
    while (mp != 0 && k < 200) begin cyc(1'b0, 1'b0); k++; end
    if (k >= 200) timeout("wait_ns_go");
    check("night_exit_remain", remain, 4);
    check("night_exit_eled", eLED01, 1);

    // Randomised traffic: irregular and back-to-back ticks, requests, night.
    nl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) nl = !nl;
      cyc_t($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, nl);
    end

    // Asynchronous reset in the middle of EW_YEL.
    k = 0;
    while (mp != 4 && k < 400) begin cyc(1'b0, 1'b0); k++; end
    if (k >= 400) timeout("wait_ew_yel");
    cyc(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_lamps", {LR1, LY1, LG1, LR2, LY2, LG2}, 6'b100_001);
    check("arst_remain", remain, 4);
    check("arst_eled", eLED01, 0);
    check("arst_ped", ped_pending, 0);
    repeat (2) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (40) cyc(1'b0, 1'b0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
